// File: rtl/rf_pkg.sv
// rf_pkg: shared encodings for the register-file sequencer and its decoder
package rf_pkg;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;
  localparam int IMM_HI = 7;
  typedef enum logic [6:0] {
    S_WAIT   = 7'b0000001,
    S_DECODE = 7'b0000010,
    S_GET_A  = 7'b0000100,
    S_GET_B  = 7'b0001000,
    S_EXEC   = 7'b0010000,
    S_WR_REG = 7'b0100000,
    S_WR_IMM = 7'b1000000
  } state_t;
  typedef struct packed {
    logic movi;
    logic movr;
    logic alu;
    logic mvn;
    logic cmp;
    logic illegal;
  } iclass_t;
endpackage

// File: rtl/rf_seq_ctrl_if.sv
// rf_seq_ctrl_if: instruction handshake plus datapath control bundle
interface rf_seq_ctrl_if #(parameter int W = 16, parameter int RW = 3);
  logic          s;
  logic [W-1:0]  in;
  logic          w;
  logic [RW-1:0] readnum;
  logic [RW-1:0] writenum;
  logic          write;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic          vsel;
  logic [1:0]    shift;
  logic [1:0]    ALUop;
  logic [W-1:0]  sximm8;
  modport master (
    output s, in,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel, shift, ALUop, sximm8
  );
  modport slave (
    input  s, in,
    output w, readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel, shift, ALUop, sximm8
  );
endinterface

// File: rtl/rf_seq_ctrl_instr_dec.sv
// instr_dec: splits IR into fields, sign-extends imm8 and classifies the instruction
module instr_dec
  import rf_pkg::*;
#(parameter int W = 16, parameter int RW = 3) (
  input  logic [W-1:0]  ir,
  output logic [RW-1:0] rn,
  output logic [RW-1:0] rd,
  output logic [RW-1:0] rm,
  output logic [1:0]    op,
  output logic [1:0]    sh,
  output logic [W-1:0]  sximm8,
  output iclass_t       cls
);
  logic [2:0] opc;
  assign opc    = ir[OPC_HI:OPC_LO];
  assign op     = ir[OP_HI:OP_LO];
  assign rn     = ir[RN_HI:RN_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign rm     = ir[RM_HI:RM_LO];
  assign sh     = ir[SH_HI:SH_LO];
  assign sximm8 = {{(W-8){ir[IMM_HI]}}, ir[IMM_HI:0]};
  // classification; MOV with op 01/11 and unknown opcodes fall out as illegal
  always_comb begin
    cls.movi    = opc == OPC_MOV && op == OP_MOVI;
    cls.movr    = opc == OPC_MOV && op == OP_MOVR;
    cls.alu     = opc == OPC_ALU;
    cls.mvn     = cls.alu && op == ALU_MVN;
    cls.cmp     = cls.alu && op == ALU_CMP;
    cls.illegal = !(cls.movi || cls.movr || cls.alu);
  end
endmodule

// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: multi-cycle Moore sequencer driving the 8x16 register file and ALU datapath
module rf_seq_ctrl
  import rf_pkg::*;
#(parameter int W = 16, parameter int RW = 3) (
  input  logic        clk,
  input  logic        reset,
  rf_seq_ctrl_if.slave bus
);
  state_t        state, nxt;
  logic [W-1:0]  ir;
  logic [RW-1:0] rn, rd, rm;
  logic [1:0]    op, sh;
  logic [W-1:0]  sximm8;
  iclass_t       cls;
  instr_dec #(.W(W), .RW(RW)) u_dec (
    .ir(ir), .rn(rn), .rd(rd), .rm(rm), .op(op), .sh(sh), .sximm8(sximm8), .cls(cls)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_WAIT;
    else state <= nxt;
  // IR captures only when a start is accepted in WAIT
  always_ff @(posedge clk or posedge reset)
    if (reset) ir <= '0;
    else if (state == S_WAIT && bus.s) ir <= bus.in;
  // next-state: MOV imm jumps to write-back, single-operand ops skip GET_A, CMP ends after EXEC
  always_comb begin
    nxt = state == S_WAIT   ? (bus.s ? S_DECODE : S_WAIT) :
          state == S_DECODE ? (cls.illegal ? S_WAIT : cls.movi ? S_WR_IMM :
                               (cls.movr || cls.mvn) ? S_GET_B : S_GET_A) :
          state == S_GET_A  ? S_GET_B :
          state == S_GET_B  ? S_EXEC :
          state == S_EXEC   ? (cls.cmp ? S_WAIT : S_WR_REG) :
          S_WAIT;
  end
  // Moore outputs decoded from the registered state only
  always_comb begin
    bus.w        = state == S_WAIT;
    bus.readnum  = state == S_GET_A ? rn : state == S_GET_B ? rm : '0;
    bus.writenum = state == S_WR_REG ? rd : state == S_WR_IMM ? rn : '0;
    bus.write    = state == S_WR_REG || state == S_WR_IMM;
    bus.loada    = state == S_GET_A;
    bus.loadb    = state == S_GET_B;
    bus.loadc    = state == S_EXEC && !cls.cmp;
    bus.loads    = state == S_EXEC && cls.cmp;
    bus.asel     = state == S_EXEC && (cls.movr || cls.mvn);
    bus.vsel     = state == S_WR_IMM;
    bus.ALUop    = (state == S_EXEC && cls.alu) ? op : ALU_ADD;
    bus.shift    = sh;
    bus.sximm8   = sximm8;
  end
endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb_rf_seq_ctrl: scoreboard-driven directed bench for the register-file sequencer
module tb_rf_seq_ctrl;
  typedef struct packed {
    logic        w;
    logic [2:0]  rn;
    logic [2:0]  wn;
    logic        wr;
    logic        la;
    logic        lb;
    logic        lc;
    logic        ls;
    logic        as;
    logic        vs;
    logic [1:0]  sh;
    logic [1:0]  aop;
    logic [15:0] sx;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  exp_t cur;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int writes = 0;
  rf_seq_ctrl_if #(.W(16), .RW(3)) bus();
  rf_seq_ctrl #(.W(16), .RW(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_comb cur = {bus.w, bus.readnum, bus.writenum, bus.write, bus.loada, bus.loadb, bus.loadc,
                     bus.loads, bus.asel, bus.vsel, bus.shift, bus.ALUop, bus.sximm8};
  always @(negedge clk) if (bus.write === 1'b1) writes++;
  task automatic chk(input string tag, input exp_t e);
    tests++;
    assert (cur === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, cur, e);
    end
  endtask
  task automatic chk_int(input string tag, input int o, input int e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  function automatic exp_t idle_vec(input logic [15:0] i);
    exp_t b;
    b = '0;
    b.w = 1'b1;
    b.sh = i[4:3];
    b.sx = {{8{i[7]}}, i[7:0]};
    return b;
  endfunction
  task automatic push_seq(input logic [15:0] i, output int nw);
    exp_t b, t;
    logic movi, movr, alu, cmp, mvn;
    b = idle_vec(i);
    b.w = 1'b0;
    movi = i[15:13] == 3'b110 && i[12:11] == 2'b10;
    movr = i[15:13] == 3'b110 && i[12:11] == 2'b00;
    alu = i[15:13] == 3'b101;
    cmp = alu && i[12:11] == 2'b01;
    mvn = alu && i[12:11] == 2'b11;
    nw = 0;
    q.push_back(b);
    if (movi) begin
      t = b; t.wn = i[10:8]; t.vs = 1'b1; t.wr = 1'b1;
      q.push_back(t);
      nw = 1;
    end else if (movr || alu) begin
      if (alu && !mvn) begin
        t = b; t.rn = i[10:8]; t.la = 1'b1;
        q.push_back(t);
      end
      t = b; t.rn = i[2:0]; t.lb = 1'b1;
      q.push_back(t);
      t = b; t.aop = alu ? i[12:11] : 2'b00; t.as = movr || mvn;
      if (cmp) t.ls = 1'b1; else t.lc = 1'b1;
      q.push_back(t);
      if (!cmp) begin
        t = b; t.wn = i[7:5]; t.wr = 1'b1;
        q.push_back(t);
        nw = 1;
      end
    end
    q.push_back(idle_vec(i));
  endtask
  task automatic run(input string name, input logic [15:0] i, input int lat, input bit busy);
    int nw, w0;
    exp_t e;
    push_seq(i, nw);
    chk_int({name, "_latency"}, q.size(), lat);
    w0 = writes;
    bus.s = 1'b1;
    bus.in = i;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      chk(name, e);
      if (q.size() > 0) begin
        bus.s = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in = busy ? 16'($urandom) : i;
      end else bus.s = 1'b0;
    end
    chk_int({name, "_writes"}, writes - w0, nw);
  endtask
  initial begin
    int w0;
    exp_t t;
    reset = 1'b1;
    bus.s = 1'b0;
    bus.in = '0;
    #12;
    chk("reset_state", idle_vec(16'h0000));
    @(negedge clk) reset = 1'b0;
    run("mov_imm", 16'hD2FB, 3, 1'b0);
    run("add", 16'hA16A, 6, 1'b0);
    run("cmp", 16'hA909, 5, 1'b0);
    run("mvn", 16'hB8A3, 5, 1'b0);
    run("mov_reg", 16'hC087, 5, 1'b0);
    run("illegal_opc", 16'hE000, 2, 1'b0);
    run("illegal_mov", 16'hC800, 2, 1'b0);
    run("and_busy", 16'hB233, 6, 1'b1);
    run("add_busy", 16'hA16A, 6, 1'b1);
    bus.s = 1'b1;
    bus.in = 16'hA16A;
    @(posedge clk); #1;
    bus.s = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    t = idle_vec(16'hA16A);
    t.w = 1'b0; t.rn = 3'd2; t.lb = 1'b1;
    chk("mid_get_b", t);
    w0 = writes;
    reset = 1'b1;
    #1;
    chk("async_reset", idle_vec(16'h0000));
    @(negedge clk) reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_reset_idle", idle_vec(16'h0000));
    end
    chk_int("post_reset_writes", writes - w0, 0);
    run("after_reset_mov", 16'hD2FB, 3, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_seq_ctrl.md
Name: rf_seq_ctrl

Overview:
- Multi-cycle sequencer for the 8x16 register file and its ALU datapath.
- Accepts one 16-bit instruction on a start pulse and latches it.
- Steps the datapath through read-A, read-B, execute and write-back using Moore outputs: readnum/writenum/write toward the register file, and load/select strobes toward the A/B/C/status registers and the ALU.
- Sits between the instruction source and the datapath, and is the only driver of register-file write.

Parameters:
- W, 16, instruction and immediate width
- RW, 3, register index width (8 registers)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- s  in  1  start; sampled only in WAIT
- in  in  W  instruction word; latched into IR when s accepted
- w  out  1  idle/ready; 1 only in WAIT
- readnum  out  RW  register-file read index
- writenum  out  RW  register-file write index
- write  out  1  register-file write enable
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C register
- loads  out  1  load status flags
- asel  out  1  1 = force ALU A input to 0
- vsel  out  1  write-back source: 0 = C, 1 = sximm8
- shift  out  2  shifter control = IR[4:3]
- ALUop  out  2  00 ADD, 01 CMP(sub), 10 AND, 11 MVN
- sximm8  out  W  IR[7:0] sign-extended to W

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- IR fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
  - Legal instructions:
    - 110/10: MOV Rn,#imm8
    - 110/00: MOV Rd,Rm{sh}
    - 101/xx: ALU Rd,Rn,Rm{sh}, where CMP writes status only and MVN uses Rm only.
- Reset: state = WAIT, IR = 0. Outputs: w = 1, write/loada/loadb/loadc/loads/asel/vsel = 0, readnum/writenum = 0, sximm8 = 0, shift = 0, ALUop = 0.
- All strobes are decoded from the registered state only (Moore). Only IR and state are registered.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM.
- WAIT:
  - w = 1.
  - If s = 1 at the edge, latch IR <= in and go to DECODE. Otherwise stay.
  - s in any other state is ignored and IR is held.
- DECODE: no strobes. Next state by instruction:
  - MOV imm -> WR_IMM
  - MOV reg -> GET_B
  - MVN -> GET_B
  - other ALU ops -> GET_A
  - illegal opcode/op -> WAIT, with no register write ever issued.
- GET_A: readnum = Rn, loada = 1. Next GET_B.
- GET_B: readnum = Rm, loadb = 1. Next EXEC.
- EXEC:
  - loadc = 1. ALUop = op for the ALU class, 00 for MOV reg.
  - asel = 1 for MOV reg and MVN, else 0.
  - For CMP: loads = 1, loadc = 0, next WAIT. Otherwise next WR_REG.
- WR_REG: writenum = Rd, vsel = 0, write = 1. Next WAIT.
- WR_IMM: writenum = Rn, vsel = 1, write = 1. Next WAIT.
- Outside their driving states, readnum and writenum = 0 and all strobes = 0. shift and sximm8 continuously reflect IR.
- Latency (edges from the edge accepting s until w = 1):
  - MOV imm: 3
  - MOV reg: 5
  - MVN: 5
  - CMP: 5
  - ADD/AND: 6
  - illegal: 2
- Back-to-back: s held high in WAIT starts the next instruction on the same edge w is observed high, giving zero idle cycles.
- Reset mid-operation: forces WAIT immediately and asynchronously. write drops combinationally, so an in-flight write-back is not committed. IR is cleared.
- Exactly one register-file write per legal non-CMP instruction. None for CMP or illegal.

Decomposition:
- Shared package rf_pkg:
  - opcode/op constants (OPC_MOV = 110, OPC_ALU = 101, OP_MOVI = 10, OP_MOVR = 00)
  - ALUop constants
  - state encoding (one-hot, 7 bits)
  - field bit positions.
- One sub-module, instr_dec: combinational field extraction from IR, sign extension of imm8, and the illegal flag.
- State register and IR are built from the existing enable-flop style.

Test Plan:
- Reset: assert reset mid-GET_B of an ADD, release -> w = 1, write = 0 immediately, IR = 0, no write-back on any following edge.
- MOV imm: in = 16'hD2FB (MOV R2,#-5), s = 1 -> WR_IMM on edge 2 with writenum = 2, vsel = 1, sximm8 = 16'hFFFB, write = 1 for exactly 1 cycle; w = 1 after edge 3.
- ADD: in = 16'hA16A (ADD R3,R1,R2, sh = 01) -> readnum sequence 1 then 2, loada then loadb, EXEC ALUop = 00 with loadc = 1, shift = 01, WR_REG writenum = 3; w after edge 6.
- CMP: in = 16'hA909 (CMP R1,R1) -> loads = 1 in EXEC, write never asserted, w after edge 5.
- MVN/MOV reg: MVN skips GET_A (loada never 1) with asel = 1 in EXEC; MOV R4,R7 likewise, ALUop = 00; both finish in 5 edges.
- Illegal and busy: in = 16'hE000 -> DECODE then WAIT, zero writes, w after edge 2. Toggling s and in during an ADD leaves IR and the sequence unchanged.
